// File: rtl/sumador_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
package sumador_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/sumador_completo.sv
// Combinational 1-bit full adder: the single arithmetic cell of the serial adder.
module sumador_completo (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/sumador_serial.sv
// Bit-serial ripple adder/subtractor, one sum bit per enabled clock, LSB first.
// Optional zero/overflow flags are built when SUMADOR_SERIAL_FLAGS_EN is defined.
module sumador_serial
  import sumador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  typedef logic [CW-1:0] cnt_t;

  state_t           state;
  cnt_t             cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic             sum_bit;
  logic             carry_bit;
  logic             last_bit;

  sumador_completo u_fa (
    .a  (a_reg[cnt]),
    .b  (b_reg[cnt]),
    .ci (carry),
    .s  (sum_bit),
    .co (carry_bit)
  );

  assign last_bit = (cnt == cnt_t'(WIDTH - 1));

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others (carry and S[cnt] rely on it).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      S     <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            carry <= cin;
            S     <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          S[cnt] <= sum_bit;
          carry  <= carry_bit;
          if (last_bit) begin
            cnt   <= '0;
            cout  <= carry_bit;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SUMADOR_SERIAL_FLAGS_EN
  logic [WIDTH-1:0] s_final;

  // Lower bits are already in S on the last edge; only the MSB is still in flight.
  assign s_final = {sum_bit, S[WIDTH-2:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (enable) begin
      if (state == IDLE && start) begin
        zero     <= 1'b0;
        overflow <= 1'b0;
      end else if (state == SHIFT && last_bit) begin
        zero     <= (s_final == '0);
        overflow <= carry ^ carry_bit;
      end
    end
  end
`else
  assign zero     = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sumador_serial.sv
// Self-checking bench for sumador_serial: directed cases plus randomized operations
// against an arithmetic reference model.
module tb_sumador_serial;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         cin = 1'b0;
  logic [W-1:0] S;
  logic         cout;
  logic         zero;
  logic         overflow;
  logic         busy;
  logic         done;

  int total = 0;
  int bad = 0;

  sumador_serial #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .A        (A),
    .B        (B),
    .cin      (cin),
    .S        (S),
    .cout     (cout),
    .zero     (zero),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: plain integer arithmetic, signed overflow from operand/result signs.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       output logic [W-1:0] es, output logic ec,
                       output logic ez, output logic eo);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    es  = sum[W-1:0];
    ec  = sum[W];
`ifdef SUMADOR_SERIAL_FLAGS_EN
    ez  = (es == '0);
    eo  = (a[W-1] == b[W-1]) && (es[W-1] != a[W-1]);
`else
    ez  = 1'b0;
    eo  = 1'b0;
`endif
  endtask

  // One full operation; enable is dropped for stall_len cycles after stall_after
  // active SHIFT edges; start can be held high through the whole operation.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input int stall_after, input int stall_len,
                        input bit hold_start);
    logic [W-1:0] es;
    logic ec, ez, eo;
    int cycles;
    int pulses;
    model(a, b, ci, es, ec, ez, eo);
    A = a; B = b; cin = ci; enable = 1'b1; start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    A = W'($urandom); B = W'($urandom); cin = 1'($urandom);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL %s busy_after_accept got=%b want=1", name, busy);
    end
    cycles = 0;
    while (done !== 1'b1 && cycles < 60) begin
      enable = (cycles >= stall_after && cycles < stall_after + stall_len) ? 1'b0 : 1'b1;
      tick();
      cycles++;
    end
    enable = 1'b1;
    total++;
    if (cycles !== W + stall_len) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", name, cycles, W + stall_len);
    end
    total++;
    if (S !== es || cout !== ec) begin
      bad++; $display("FAIL %s sum got=%h/%b want=%h/%b", name, S, cout, es, ec);
    end
    total++;
    if (zero !== ez || overflow !== eo) begin
      bad++; $display("FAIL %s flags z/o got=%b%b want=%b%b", name, zero, overflow, ez, eo);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s busy_in_done got=%b want=0", name, busy);
    end
    pulses = (done === 1'b1) ? 1 : 0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    total++;
    if (pulses !== 1 || busy !== 1'b0) begin
      bad++; $display("FAIL %s done_pulses got=%0d busy=%b want=1 busy=0", name, pulses, busy);
    end
    total++;
    if (S !== es) begin
      bad++; $display("FAIL %s S_held got=%h want=%h", name, S, es);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    total++;
    if ({S, cout, zero, overflow, busy, done} !== '0) begin
      bad++; $display("FAIL reset_values got=%h/%b%b%b%b%b want=all zero",
                      S, cout, zero, overflow, busy, done);
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_op("sub_5_3", 8'h05, 8'hFC, 1'b1, 0, 0, 1'b0);
    run_op("signed_ovf", 8'h7F, 8'h01, 1'b0, 0, 0, 1'b0);
    run_op("wrap_zero_held_start", 8'hFF, 8'h01, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_stall();
    run_op("stall3", 8'h05, 8'hFC, 1'b1, 3, 3, 1'b0);
    // Frozen in DONE: done must stay high while enable is low.
    A = 8'h11; B = 8'h22; cin = 1'b0; start = 1'b1; enable = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < W; k++) tick();
    enable = 1'b0;
    tick(); tick();
    total++;
    if (done !== 1'b1 || S !== 8'h33) begin
      bad++; $display("FAIL freeze_done got done=%b S=%h want done=1 S=33", done, S);
    end
    enable = 1'b1;
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL release_done got=%b want=0", done);
    end
  endtask

  task automatic test_reset_mid();
    A = 8'h0F; B = 8'h00; cin = 1'b0; start = 1'b1; enable = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (S !== 8'h0F || busy !== 1'b1) begin
      bad++; $display("FAIL partial_before_reset got S=%h busy=%b want S=0f busy=1", S, busy);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || S !== '0 || cout !== 1'b0) begin
      bad++; $display("FAIL async_abort got busy=%b done=%b S=%h cout=%b want 0", busy, done, S, cout);
    end
    tick();
    reset = 1'b0;
    tick();
    run_op("after_reset", 8'h10, 8'h20, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int sa, sl;
      sa = $urandom_range(0, W - 1);
      sl = (n % 3 == 0) ? $urandom_range(1, 4) : 0;
      run_op($sformatf("rand%0d", n), W'($urandom), W'($urandom), 1'($urandom), sa, sl,
             1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] es;
    logic ec, ez, eo;
    model(8'hA5, 8'h5A, 1'b1, es, ec, ez, eo);
    A = 8'h3C; B = 8'hC3; cin = 1'b1; start = 1'b1; enable = 1'b1;
    tick();
    for (int k = 0; k < W + 1; k++) tick();
    // Now back in IDLE at the earliest accept edge with start still high.
    A = 8'hA5; B = 8'h5A; cin = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL b2b_accept busy got=%b want=1", busy);
    end
    for (int k = 0; k < W; k++) tick();
    total++;
    if (done !== 1'b1 || S !== es || cout !== ec) begin
      bad++; $display("FAIL b2b_result got done=%b S=%h c=%b want 1 %h %b", done, S, cout, es, ec);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
